// File: rtl/npc_pkg.sv
// npc_pkg: shared FSM encoding, owner tags, memop codes and timeout default
package npc_pkg;
  localparam int TIMEOUT_CYC_DEF = 256;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;
  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;
  localparam logic [2:0] MEMOP_SB  = 3'b000;
  localparam logic [2:0] MEMOP_SH  = 3'b001;
  localparam logic [2:0] MEMOP_SW  = 3'b010;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory handshakes seen by the arbiter
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_wen;
  logic [2:0]  lsu_memop;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] memdata;
  logic        mem_wen;
  logic [2:0]  memop;
  logic        mem_resp_valid;
  logic [31:0] mem_data;
  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen, lsu_memop,
           mem_req_ready, mem_resp_valid, mem_data,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
           lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
           mem_req_valid, mem_addr, memdata, mem_wen, memop
  );
  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen, lsu_memop,
           mem_req_ready, mem_resp_valid, mem_data,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
           lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
           mem_req_valid, mem_addr, memdata, mem_wen, memop
  );
endinterface

// File: rtl/mem_watchdog.sv
// mem_watchdog: saturating cycle counter flagging an outstanding access that ran too long
module mem_watchdog
  import npc_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (enable && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired = enable && cnt_q == LAST;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter onto one memory port, one access outstanding
module mem_arbiter
  import npc_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d, last_q, last_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]  memop_q, memop_d;
  logic        wen_q, wen_d, err_q, err_d;
  logic        idle, grant_ifu, grant_lsu, req_on, resp_on, expired;
  mem_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == IDLE),
    .enable (state_q == REQ || state_q == WAIT),
    .expired(expired)
  );
  always_comb begin
    idle      = state_q == IDLE && !rst;
    grant_lsu = idle && bus.lsu_req_valid && (!bus.ifu_req_valid || last_q == OWN_IFU);
    grant_ifu = idle && bus.ifu_req_valid && !grant_lsu;
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    memop_d   = memop_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (grant_ifu || grant_lsu) begin
        state_d = REQ;
        owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
        last_d  = grant_lsu ? OWN_LSU : OWN_IFU;
        addr_d  = grant_lsu ? bus.lsu_addr : bus.ifu_addr;
        wdata_d = grant_lsu ? bus.lsu_wdata : '0;
        wen_d   = grant_lsu && bus.lsu_wen;
        memop_d = grant_lsu ? bus.lsu_memop : MEMOP_LW;
      end
      REQ: if (bus.mem_req_ready) state_d = WAIT;
        else if (expired) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      WAIT: if (bus.mem_resp_valid) begin
          state_d = RESP;
          rdata_d = wen_q ? '0 : bus.mem_data;
          err_d   = 1'b0;
        end else if (expired) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      RESP: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_IFU;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      memop_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      memop_q <= memop_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // outputs are gated so that reset and non-pulsing cycles present all zeros
  assign req_on             = state_q == REQ && !rst;
  assign resp_on            = state_q == RESP && !rst;
  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.mem_req_valid  = req_on;
  assign bus.mem_addr       = req_on ? addr_q : '0;
  assign bus.memdata        = req_on ? wdata_q : '0;
  assign bus.mem_wen        = req_on && wen_q;
  assign bus.memop          = req_on ? memop_q : '0;
  assign bus.ifu_resp_valid = resp_on && owner_q == OWN_IFU;
  assign bus.ifu_rdata      = bus.ifu_resp_valid ? rdata_q : '0;
  assign bus.ifu_err        = bus.ifu_resp_valid && err_q;
  assign bus.lsu_resp_valid = resp_on && owner_q == OWN_LSU;
  assign bus.lsu_rdata      = bus.lsu_resp_valid ? rdata_q : '0;
  assign bus.lsu_err        = bus.lsu_resp_valid && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario checks of the memory arbiter with TIMEOUT_CYC=16
module tb_mem_arbiter;
  import npc_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT_CYC(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wdata      = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_memop      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_data       = '0;
  endtask
  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    bus.ifu_req_valid  = 1'b1;
    bus.lsu_req_valid  = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_data       = 32'hFFFF_FFFF;
    tick();
    tick();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.mem_wen, bus.memop,
         bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_err, bus.lsu_err} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {bus.ifu_req_ready, bus.lsu_req_ready,
               bus.mem_req_valid, bus.mem_wen, bus.memop, bus.ifu_resp_valid,
               bus.lsu_resp_valid, bus.ifu_err, bus.lsu_err});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.memdata, bus.ifu_rdata, bus.lsu_rdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {bus.mem_addr, bus.memdata, bus.ifu_rdata, bus.lsu_rdata});
    end
    idle_inputs();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want 000",
               {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid});
    end
  endtask
  task automatic test_ifu_fetch;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_accept: got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_req_valid, bus.mem_addr, bus.memdata, bus.mem_wen, bus.memop, bus.ifu_resp_valid}
        !== {1'b1, 32'h8000_0000, 32'h0, 1'b0, 3'b010, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_req: got %h want %h", {bus.mem_req_valid, bus.mem_addr, bus.memdata,
               bus.mem_wen, bus.memop, bus.ifu_resp_valid},
               {1'b1, 32'h8000_0000, 32'h0, 1'b0, 3'b010, 1'b0});
    end
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_data       = 32'h0010_0073;
    #1;
    n_cmp++;
    if ({bus.mem_req_valid, bus.ifu_resp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_wait: got %b want 00", {bus.mem_req_valid, bus.ifu_resp_valid});
    end
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_data       = '0;
    #1;
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_err, bus.lsu_resp_valid}
        !== {1'b1, 32'h0010_0073, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_resp: got %h want %h",
               {bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_err, bus.lsu_resp_valid},
               {1'b1, 32'h0010_0073, 1'b0, 1'b0});
    end
    tick();
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_err} !== 34'b0) begin
      n_fail++;
      $display("FAIL fetch_pulse_end: got %h want 0",
               {bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_err});
    end
  endtask
  task automatic test_both_valid;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0004;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_0100;
    bus.lsu_wdata     = 32'h55AA_55AA;
    bus.lsu_wen       = 1'b0;
    bus.lsu_memop     = MEMOP_LBU;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL both_first_grant: got %b want 01", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    tick();
    bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_addr, bus.memdata, bus.mem_wen, bus.memop}
        !== {2'b00, 32'h8000_0100, 32'h55AA_55AA, 1'b0, 3'b100}) begin
      n_fail++;
      $display("FAIL both_lsu_req: got %h want %h", {bus.ifu_req_ready, bus.lsu_req_ready,
               bus.mem_addr, bus.memdata, bus.mem_wen, bus.memop},
               {2'b00, 32'h8000_0100, 32'h55AA_55AA, 1'b0, 3'b100});
    end
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_data       = 32'h1122_3344;
    #1;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_rdata, bus.lsu_err}
        !== {2'b10, 32'h1122_3344, 1'b0}) begin
      n_fail++;
      $display("FAIL both_lsu_resp: got %h want %h",
               {bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_rdata, bus.lsu_err},
               {2'b10, 32'h1122_3344, 1'b0});
    end
    tick();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.lsu_resp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL both_second_grant: got %b want 100",
               {bus.ifu_req_ready, bus.lsu_req_ready, bus.lsu_resp_valid});
    end
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_addr, bus.memop, bus.mem_wen} !== {32'h8000_0004, 3'b010, 1'b0}) begin
      n_fail++;
      $display("FAIL both_ifu_req: got %h want %h", {bus.mem_addr, bus.memop, bus.mem_wen},
               {32'h8000_0004, 3'b010, 1'b0});
    end
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_data       = 32'hAABB_CCDD;
    #1;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata} !== {2'b10, 32'hAABB_CCDD}) begin
      n_fail++;
      $display("FAIL both_ifu_resp: got %h want %h",
               {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata}, {2'b10, 32'hAABB_CCDD});
    end
    tick();
  endtask
  task automatic test_store_stall;
    idle_inputs();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wen       = 1'b1;
    bus.lsu_memop     = MEMOP_SW;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL store_accept: got %b want 01", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0020;
    for (int i = 0; i < 6; i++) begin
      bus.mem_req_ready = (i == 5);
      if (i == 5) bus.ifu_req_valid = 1'b0;
      #1;
      n_cmp++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.memdata, bus.mem_wen, bus.memop, bus.ifu_req_ready}
          !== {1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b0}) begin
        n_fail++;
        $display("FAIL store_hold[%0d]: got %h want %h", i, {bus.mem_req_valid, bus.mem_addr,
                 bus.memdata, bus.mem_wen, bus.memop, bus.ifu_req_ready},
                 {1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b0});
      end
      tick();
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_data       = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({bus.mem_req_valid, bus.lsu_resp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL store_wait: got %b want 00", {bus.mem_req_valid, bus.lsu_resp_valid});
    end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_err} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL store_resp: got %h want %h",
               {bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_err}, {1'b1, 32'h0, 1'b0});
    end
    tick();
  endtask
  task automatic test_timeout;
    idle_inputs();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    bus.lsu_memop     = MEMOP_LW;
    #1;
    n_cmp++;
    if (bus.lsu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_accept: got %b want 1", bus.lsu_req_ready);
    end
    tick();
    bus.lsu_req_valid = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      bus.mem_req_ready = (k == 0);
      #1;
      n_cmp++;
      if (bus.lsu_resp_valid !== (k == 16)) begin
        n_fail++;
        $display("FAIL timeout_pulse[%0d]: got %b want %b", k, bus.lsu_resp_valid, k == 16);
      end
      if (k == 16) begin
        n_cmp++;
        if ({bus.lsu_err, bus.lsu_rdata} !== {1'b1, 32'h0}) begin
          n_fail++;
          $display("FAIL timeout_err: got %h want %h", {bus.lsu_err, bus.lsu_rdata}, {1'b1, 32'h0});
        end
      end
      tick();
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_data       = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.mem_req_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL late_resp_idle: got %b want 00", {bus.lsu_resp_valid, bus.mem_req_valid});
    end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_rdata} !== 34'b0) begin
      n_fail++;
      $display("FAIL late_resp_ignored: got %h want 0",
               {bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_rdata});
    end
  endtask
  task automatic test_reset_mid;
    idle_inputs();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_3000;
    #1;
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.ifu_req_valid = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid,
         bus.lsu_resp_valid, bus.mem_addr} !== 37'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h want 0", {bus.ifu_req_ready, bus.lsu_req_ready,
               bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_addr});
    end
    tick();
    rst = 1'b0;
    bus.ifu_req_valid  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_data       = 32'hBAD0_BAD0;
    #1;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata} !== 34'b0) begin
      n_fail++;
      $display("FAIL mid_reset_stale: got %h want 0",
               {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata});
    end
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0010;
    #1;
    n_cmp++;
    if (bus.ifu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_accept: got %b want 1", bus.ifu_req_ready);
    end
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_req_valid, bus.mem_addr} !== {1'b1, 32'h8000_0010}) begin
      n_fail++;
      $display("FAIL after_reset_req: got %h want %h", {bus.mem_req_valid, bus.mem_addr},
               {1'b1, 32'h8000_0010});
    end
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_data       = 32'h0000_0013;
    #1;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_err} !== {1'b1, 32'h0000_0013, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_resp: got %h want %h",
               {bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_err}, {1'b1, 32'h0000_0013, 1'b0});
    end
    tick();
    n_cmp++;
    if (bus.ifu_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_pulse_end: got %b want 0", bus.ifu_resp_valid);
    end
  endtask
  initial begin
    test_reset();
    test_ifu_fetch();
    test_both_valid();
    test_store_stall();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 256: cycles allowed from request issue to response before an error response is generated.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ifu_req_valid / ifu_req_ready  input / output  1 / 1  fetch request handshake.
REQ-005 ifu_addr  input  32  fetch address.
REQ-006 ifu_resp_valid / ifu_rdata / ifu_err  output  1 / 32 / 1  fetch response: one-cycle pulse, instruction word, timeout flag.
REQ-007 lsu_req_valid / lsu_req_ready  input / output  1 / 1  load/store request handshake.
REQ-008 lsu_addr / lsu_wdata  input  32 / 32  data address, store data.
REQ-009 lsu_wen / lsu_memop  input  1 / 3  store enable; access size/sign code (funct3 encoding).
REQ-010 lsu_resp_valid / lsu_rdata / lsu_err  output  1 / 32 / 1  load/store response pulse, load data, timeout flag.
REQ-011 mem_req_valid / mem_req_ready  output / input  1 / 1  memory request handshake.
REQ-012 mem_addr / memdata / mem_wen / memop  output  32 / 32 / 1 / 3  memory request payload.
REQ-013 mem_resp_valid / mem_data  input  1 / 32  memory response strobe and read data.

Function
REQ-014 The block SHALL use a four-state FSM: IDLE, REQ, WAIT, RESP.
REQ-015 In IDLE, the block SHALL assert ready combinationally to exactly one valid requester.
- The handshake completes in that cycle.
- The block SHALL latch the request payload and the grant owner, then move to REQ.
REQ-016 Arbitration when only one requester is valid: that requester wins.
REQ-017 Arbitration when both requesters are valid: the requester not granted last time wins. After reset, last-grant SHALL be IFU, so the LSU wins first.
REQ-018 An IFU grant SHALL drive the memory request as follows: memop=3'b010, mem_wen=0, memdata=0.
REQ-019 An LSU grant SHALL forward lsu_memop, lsu_wen and lsu_wdata unchanged.
REQ-020 In REQ, mem_req_valid SHALL be 1 and the payload SHALL be held stable.
- mem_req_valid&&mem_req_ready SHALL move the FSM to WAIT.
- mem_req_valid SHALL drop in the following cycle.
REQ-021 In WAIT, mem_resp_valid SHALL capture mem_data, with err=0, and move the FSM to RESP.
- Stores SHALL also wait for mem_resp_valid (write acknowledge); rdata SHALL be 0 for stores.
REQ-022 In RESP, only the owner's resp_valid SHALL pulse high for exactly one cycle, with latched rdata and err. The FSM SHALL then return to IDLE.
REQ-023 No ready SHALL be asserted outside IDLE, so at most one transaction is outstanding.
REQ-024 Minimum latency is 3 cycles from the accept edge to the response pulse, given zero-wait mem_req_ready and a next-cycle mem_resp_valid.
REQ-025 Timeout counter:
- It SHALL clear on entering REQ and increment every cycle in REQ or WAIT.
- On reaching TIMEOUT_CYC-1 without completion, the FSM SHALL go to RESP with err=1 and rdata=0.
- Completion and timeout in the same cycle: completion wins.
REQ-026 mem_resp_valid received in IDLE, REQ or RESP SHALL be ignored. This includes a late response after a timeout.
REQ-027 All response outputs SHALL be 0 whenever they are not pulsing.

Reset
REQ-028 When rst=1, the block SHALL at the next edge:
- set FSM=IDLE, last-grant=IFU, counter=0;
- clear latched payload, rdata and err.
REQ-029 While rst=1, all outputs SHALL be 0 (all readies, mem_req_valid, resp pulses, payloads).
REQ-030 Reset mid-transaction SHALL abandon the transaction with no response pulse; a subsequent stale mem_resp_valid SHALL be ignored per REQ-026.

Structure
REQ-031 The FSM state encoding, memop codes (LB..LHU, SB..SW) and the TIMEOUT_CYC default SHALL live in shared package npc_pkg.
REQ-032 The timeout counter SHALL be a sub-module mem_watchdog (inputs clear and enable; output expired).

Verification
REQ-033 Reset, then IFU-only request at addr 0x80000000; memory ready immediately and responds 0x00100073 the next cycle -> ifu_resp_valid one pulse with ifu_rdata=0x00100073, err=0, 3 cycles after accept.
REQ-034 Both valid in the same IDLE cycle after reset -> LSU granted first; once that response returns, with both still valid, IFU granted next.
REQ-035 LSU store: addr 0x80001000, wdata 0xDEADBEEF, memop 3'b010, wen=1; mem_req_ready held low for 5 cycles -> payload stable throughout; lsu_resp_valid with rdata=0 after the ack.
REQ-036 LSU load with no mem_resp_valid for TIMEOUT_CYC=16 -> lsu_resp_valid, lsu_err=1, rdata=0 on the 16th cycle after REQ entry; a late mem_resp_valid then produces no pulse.
REQ-037 rst asserted during WAIT -> no response pulse; all outputs 0; next IFU request is served normally.
